// File: rtl/get_rssi_param_pkg.sv
// Shared defaults and sizing helpers for the RSSI estimator.
package get_rssi_param_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_LW = 6;
  localparam int DEF_RW = 7;

  // A counter that must reach 2^log2_depth needs one bit more than the index.
  function automatic int cnt_w(input int log2_depth);
    return log2_depth + 1;
  endfunction

endpackage

// File: rtl/get_rssi_param_delay_line.sv
// Strobe-gated delay line: q shows the value written DEPTH writes ago.
module rssi_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage is intentionally unreset; the owner masks it until DEPTH writes land.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      mem[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign q = mem[DEPTH-1];

endmodule

// File: rtl/get_rssi_param.sv
// RSSI estimator: moving averages of high- and low-level samples, their
// clamped difference, and a second moving average of that difference.
module get_rssi_param
  import get_rssi_param_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW,
  parameter int RW = DEF_RW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          den,
  input  logic          bin,
  input  logic          ben,
  output logic [DW-1:0] dout,
  output logic          drdy,
  output logic          sat
);

  localparam int LCW = cnt_w(LW);
  localparam int RCW = cnt_w(RW);
  localparam int LSW = DW + LW;
  localparam int RSW = DW + RW;

  function automatic logic [LSW-1:0] widen_lvl(input logic [DW-1:0] v);
    return {{LW{1'b0}}, v};
  endfunction

  function automatic logic [RSW-1:0] widen_rssi(input logic [DW-1:0] v);
    return {{RW{1'b0}}, v};
  endfunction

  // Returns {clamped, value}; a negative difference becomes zero.
  function automatic logic [DW:0] clamp_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [DW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d[DW]) return {1'b1, {DW{1'b0}}};
    return {1'b0, d[DW-1:0]};
  endfunction

  logic           hstb, lstb;
  logic [DW-1:0]  hold_q, lold_q, rold_q;
  logic [LSW-1:0] hsum, lsum;
  logic [LCW-1:0] hcnt, lcnt;
  logic           hfull, lfull;
  logic           hvld_p0, lvld_p0;
  logic [DW-1:0]  havg, lavg, hhold, lhold, hcur;
  logic [DW:0]    diff;
  logic [DW-1:0]  rssi_p1;
  logic           vld_p1, sat_p1;
  logic [RSW-1:0] rsum;
  logic [RCW-1:0] rcnt;
  logic           rfull, rfull_nxt;
  logic           vld_p2;

  assign hstb  = ben & den & bin;
  assign lstb  = ben & den & ~bin;
  assign hfull = hcnt[LW];
  assign lfull = lcnt[LW];

  rssi_delay_line #(.WIDTH(DW), .DEPTH(2**LW)) u_high_dl (
    .clk(clk), .ce(hstb), .d(din), .q(hold_q)
  );

  rssi_delay_line #(.WIDTH(DW), .DEPTH(2**LW)) u_low_dl (
    .clk(clk), .ce(lstb), .d(din), .q(lold_q)
  );

  // Stage p0: per-level running sums
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsum    <= '0;
      lsum    <= '0;
      hcnt    <= '0;
      lcnt    <= '0;
      hvld_p0 <= 1'b0;
      lvld_p0 <= 1'b0;
    end else begin
      hvld_p0 <= hstb;
      lvld_p0 <= lstb;
      if (hstb) begin
        hsum <= hsum + widen_lvl(din) - (hfull ? widen_lvl(hold_q) : '0);
        if (!hfull) hcnt <= hcnt + LCW'(1);
      end
      if (lstb) begin
        lsum <= lsum + widen_lvl(din) - (lfull ? widen_lvl(lold_q) : '0);
        if (!lfull) lcnt <= lcnt + LCW'(1);
      end
    end
  end

  assign havg = hsum[LSW-1:LW];
  assign lavg = lsum[LSW-1:LW];
  assign hcur = hvld_p0 ? havg : hhold;
  assign diff = clamp_diff(hcur, lhold);

  // Stage p1: level holds and clamped RSSI sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hhold  <= '0;
      lhold  <= '0;
      vld_p1 <= 1'b0;
      sat_p1 <= 1'b0;
    end else begin
      if (hvld_p0) hhold <= havg;
      if (lvld_p0) lhold <= lavg;
      vld_p1 <= hvld_p0 & hfull & lfull;
      sat_p1 <= hvld_p0 & hfull & lfull & diff[DW];
    end
  end

  always_ff @(posedge clk) begin
    if (hvld_p0) rssi_p1 <= diff[DW-1:0];
  end

  rssi_delay_line #(.WIDTH(DW), .DEPTH(2**RW)) u_rssi_dl (
    .clk(clk), .ce(vld_p1), .d(rssi_p1), .q(rold_q)
  );

  assign rfull     = rcnt[RW];
  assign rfull_nxt = rfull | (&rcnt[RW-1:0]);

  // Stage p2: RSSI running sum and output strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsum   <= '0;
      rcnt   <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1 & rfull_nxt;
      if (vld_p1) begin
        rsum <= rsum + widen_rssi(rssi_p1) - (rfull ? widen_rssi(rold_q) : '0);
        if (!rfull) rcnt <= rcnt + RCW'(1);
      end
    end
  end

  assign dout = rsum[RSW-1:RW];
  assign drdy = vld_p2;
  assign sat  = sat_p1;

endmodule

// File: tb/tb_get_rssi_param.sv
// Bench for get_rssi_param: scenario tasks checked against a queue-based model.
`timescale 1ns/1ps
module tb_get_rssi_param;

  localparam int DW = 8;
  localparam int LW = 6;
  localparam int RW = 7;
  localparam int HD = 64;
  localparam int RD = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          den = 1'b0;
  logic          bin = 1'b0;
  logic          ben = 1'b0;
  logic [DW-1:0] dout;
  logic          drdy;
  logic          sat;

  always #5 clk = ~clk;

  get_rssi_param #(.DW(DW), .LW(LW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .din(din), .den(den), .bin(bin), .ben(ben),
    .dout(dout), .drdy(drdy), .sat(sat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: last 64 high, last 64 low, last 128 RSSI values.
  int hq_m[$];
  int lq_m[$];
  int rq_m[$];
  int dout_m = 0;

  // Expected / observed results of the most recent send().
  bit            ev, es, erdy;
  int            er;
  logic          ov, os, ordy, ostray;
  logic [DW-1:0] orr, odout;

  int mon_rdy_q[$];
  int mon_sat = 0;

  always @(negedge clk) begin
    if (drdy === 1'b1) mon_rdy_q.push_back(int'(dout));
    if (sat === 1'b1) mon_sat++;
  end

  task automatic model_clear();
    hq_m.delete();
    lq_m.delete();
    rq_m.delete();
    dout_m = 0;
  endtask

  task automatic model_step(input bit b, input int d, output bit vld, output int rssi,
                            output bit satx, output bit rdy);
    vld = 0; rssi = 0; satx = 0; rdy = 0;
    if (b) begin
      hq_m.push_back(d);
      if (hq_m.size() > HD) void'(hq_m.pop_front());
    end else begin
      lq_m.push_back(d);
      if (lq_m.size() > HD) void'(lq_m.pop_front());
    end
    if (b && hq_m.size() == HD && lq_m.size() == HD) begin
      int hs, ls, rs, df;
      hs = 0; ls = 0; rs = 0;
      foreach (hq_m[i]) hs += hq_m[i];
      foreach (lq_m[i]) ls += lq_m[i];
      df = hs / HD - ls / HD;
      vld = 1;
      if (df < 0) begin satx = 1; rssi = 0; end
      else rssi = df;
      rq_m.push_back(rssi);
      if (rq_m.size() > RD) void'(rq_m.pop_front());
      foreach (rq_m[i]) rs += rq_m[i];
      dout_m = rs / RD;
      rdy = (rq_m.size() == RD);
    end
  endtask

  // One isolated strobe, then observation of the three following cycles.
  task automatic send(input bit b, input int d);
    model_step(b, d, ev, er, es, erdy);
    den = 1; ben = 1; bin = b; din = DW'(d);
    @(negedge clk);
    den = 0; ben = 0;
    ostray = drdy | sat;
    @(negedge clk);
    ov = dut.vld_p1; orr = dut.rssi_p1; os = sat;
    ostray = ostray | drdy;
    @(negedge clk);
    ordy = drdy; odout = dout;
    ostray = ostray | sat;
  endtask

  task automatic ignored(input bit b);
    ben = 1; den = 0; bin = b; din = DW'($urandom);
    @(negedge clk);
    ben = 0; den = 1;
    @(negedge clk);
    den = 0;
  endtask

  task automatic do_reset();
    den = 0; ben = 0; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; den = 1; ben = 1; bin = 1; din = 8'd200;
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (dout !== '0 || drdy !== 1'b0 || sat !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold dout=%0d drdy=%b sat=%b want 0/0/0", dout, drdy, sat);
      end
    end
    den = 0; ben = 0; rst = 0;
    model_clear();
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if (dout !== '0 || drdy !== 1'b0 || sat !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle dout=%0d drdy=%b sat=%b want 0/0/0", dout, drdy, sat);
      end
    end
  endtask

  task automatic test_fill(input string tag);
    for (int i = 0; i < HD - 1; i++) begin
      if (i == 10 || i == 20 || i == 30) ignored(1'b0);
      send(1'b0, 10);
      n_checks++;
      if (ordy !== 1'b0 || ostray !== 1'b0 || ov !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_low i=%0d drdy=%b stray=%b vld=%b want 0", tag, i, ordy, ostray, ov);
      end
    end
    for (int i = 0; i < HD - 1; i++) begin
      if (i == 5 || i == 25 || i == 45) ignored(1'b1);
      send(1'b1, 50);
      n_checks++;
      if (ov !== ev || ordy !== erdy || os !== es || ostray !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_high i=%0d vld=%b drdy=%b sat=%b stray=%b want vld=%b drdy=%b sat=%b",
                 tag, i, ov, ordy, os, ostray, ev, erdy, es);
      end
    end
    send(1'b0, 10);
    send(1'b1, 50);
    n_checks++;
    if (ov !== ev || int'(orr) != er || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_first_rssi vld=%b rssi=%0d want vld=1 rssi=%0d", tag, ov, orr, er);
    end
    n_checks++;
    if (ordy !== erdy || os !== es || int'(odout) != dout_m) begin
      n_fail++;
      $display("FAIL %s_first_out drdy=%b sat=%b dout=%0d want %b/%b/%0d",
               tag, ordy, os, odout, erdy, es, dout_m);
    end
  endtask

  task automatic test_steady();
    for (int i = 0; i < RD; i++) begin
      send(1'b0, 10);
      send(1'b1, 50);
      n_checks++;
      if (ordy !== erdy || os !== es || int'(odout) != dout_m || ostray !== 1'b0) begin
        n_fail++;
        $display("FAIL steady i=%0d drdy=%b sat=%b dout=%0d stray=%b want %b/%b/%0d/0",
                 i, ordy, os, odout, ostray, erdy, es, dout_m);
      end
    end
    n_checks++;
    if (odout !== 8'd40 || ordy !== 1'b1) begin
      n_fail++;
      $display("FAIL steady_final dout=%0d drdy=%b want 40/1", odout, ordy);
    end
  endtask

  task automatic test_step();
    logic [DW-1:0] prev;
    prev = dout;
    for (int i = 0; i < HD + RD; i++) begin
      send(1'b0, 10);
      send(1'b1, 114);
      n_checks++;
      if (odout < prev || int'(odout) != dout_m || ordy !== erdy) begin
        n_fail++;
        $display("FAIL step i=%0d dout=%0d prev=%0d drdy=%b want dout=%0d drdy=%b",
                 i, odout, prev, ordy, dout_m, erdy);
      end
      prev = odout;
    end
    n_checks++;
    if (odout !== 8'd104) begin
      n_fail++;
      $display("FAIL step_final dout=%0d want 104", odout);
    end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < HD + RD; i++) begin
      send(1'b0, 50);
      send(1'b1, 10);
      n_checks++;
      if (os !== es || ordy !== erdy || int'(odout) != dout_m || int'(orr) != er) begin
        n_fail++;
        $display("FAIL clamp i=%0d sat=%b drdy=%b dout=%0d rssi=%0d want %b/%b/%0d/%0d",
                 i, os, ordy, odout, orr, es, erdy, dout_m, er);
      end
    end
    n_checks++;
    if (odout !== '0 || os !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_final dout=%0d sat=%b want 0/1", odout, os);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    den = 1; ben = 1; bin = 1; din = 8'd10;
    @(negedge clk);
    den = 0; ben = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    model_clear();
    repeat (6) begin
      if (drdy !== 1'b0 || sat !== 1'b0 || dout !== '0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse bad_cycles=%0d want 0", bad);
    end
    test_fill("refill");
  endtask

  task automatic test_back_to_back();
    int exp_q[$];
    int exp_sat;
    int mode, d, rs;
    bit b, v, s, r;
    exp_sat = 0;
    do_reset();
    mon_rdy_q.delete();
    mon_sat = 0;
    for (int i = 0; i < 1600; i++) begin
      mode = (i < 700) ? 2 : int'($urandom_range(0, 3));
      if (mode == 2) b = (i % 2 == 1);
      else b = 1'($urandom_range(0, 1));
      d = b ? int'($urandom_range(64, 255)) : int'($urandom_range(0, 191));
      den = 0; ben = 0; bin = b; din = DW'(d);
      if (mode == 1) ben = 1;
      if (mode >= 2) begin
        den = 1; ben = 1;
        model_step(b, d, v, rs, s, r);
        if (s) exp_sat++;
        if (r) exp_q.push_back(dout_m);
      end
      @(negedge clk);
    end
    den = 0; ben = 0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (mon_rdy_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL b2b_drdy_count got %0d want %0d", mon_rdy_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (mon_rdy_q[i] != exp_q[i]) begin
          n_fail++;
          $display("FAIL b2b_dout idx=%0d got %0d want %0d", i, mon_rdy_q[i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (mon_sat != exp_sat) begin
      n_fail++;
      $display("FAIL b2b_sat_count got %0d want %0d", mon_sat, exp_sat);
    end
    n_checks++;
    if (int'(dout) != dout_m) begin
      n_fail++;
      $display("FAIL b2b_final_dout got %0d want %0d", dout, dout_m);
    end
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill("fill");
    test_steady();
    test_step();
    test_clamp();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/get_rssi_param.md
GET_RSSI_PARAM -- requirements
Module: get_rssi_param

Interface
REQ-001 SHALL have parameter DW, default 8: sample and RSSI width in bits.
REQ-002 SHALL have parameter LW, default 6: log2 of the per-level averaging window (64 samples).
REQ-003 SHALL have parameter RW, default 7: log2 of the RSSI averaging window (128 values).
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port din, input, DW: unsigned sample amplitude.
REQ-007 SHALL have port den, input, 1: din valid.
REQ-008 SHALL have port bin, input, 1: demodulated bit level (1 = high, 0 = low).
REQ-009 SHALL have port ben, input, 1: bit strobe.
REQ-010 SHALL have port dout, output, DW: averaged RSSI.
REQ-011 SHALL have port drdy, output, 1: one-cycle pulse, dout updated.
REQ-012 SHALL have port sat, output, 1: one-cycle pulse, RSSI difference clamped to zero.

Function
REQ-013 SHALL define a sample strobe as ben & den; ben without den SHALL be ignored with no state change.
REQ-014 SHALL route each strobe to the high path when bin = 1 and to the low path when bin = 0; exactly one path updates per strobe.
REQ-015 Each level path SHALL keep its own 2^LW-deep delay line, written only on its own strobes.
REQ-016 Each level path SHALL keep a sum of width DW+LW, updated in one cycle as sum + din - oldest; oldest SHALL be taken as 0 until that path has received 2^LW strobes.
REQ-017 Each level path SHALL keep a fill counter that saturates at 2^LW; the path average SHALL be sum >> LW and is valid only once the counter has saturated.
REQ-018 Each level path SHALL register its average into a hold register on the cycle after its sum update.
REQ-019 The RSSI value SHALL be computed only on a high-path update, and only when both level averages are valid.
REQ-020 The RSSI value SHALL be high_avg - low_avg, using the freshly updated high average and the held low average.
REQ-021 If high_avg < low_avg, the RSSI value SHALL be 0 and sat SHALL pulse in the same cycle the value is produced.
REQ-022 The RSSI path SHALL use a 2^RW-deep delay line and a sum of width DW+RW, applying the same oldest-is-0-until-filled rule and a saturating fill counter.
REQ-023 dout SHALL equal rsum >> RW and SHALL hold its value between updates.
REQ-024 drdy SHALL pulse only once the RSSI fill counter has saturated.
REQ-025 Latency: a high strobe sampled at edge k SHALL give a high-sum update at k, an RSSI value at k+1, an rsum update at k+2, and drdy high for the cycle following edge k+2.
REQ-026 Back-to-back strobes on every cycle SHALL be accepted without loss; each stage is single-cycle with no backpressure.
REQ-027 Sums SHALL never overflow, since the widths above are exact.

Reset
REQ-028 While rst is high, all sums, fill counters, hold registers, dout, drdy and sat SHALL be 0.
REQ-029 Assertion of rst mid-operation SHALL immediately abandon in-flight pipeline stages, with no pulse after release.
REQ-030 Delay-line storage SHALL need no reset, because the zero-until-filled rule masks stale contents.

Structure
REQ-031 A shared package SHALL hold the default parameter values and the fill-counter width helper (log2 depth + 1).
REQ-032 A single sub-module, rssi_delay_line (parameters WIDTH and DEPTH; ports clk, ce, d, q = value written DEPTH writes ago), SHALL be instantiated three times.

Verification
REQ-033 Reset check: after rst, with no strobes, dout = 0, drdy = 0 and sat = 0 indefinitely.
REQ-034 Fill gating: 63 low and 63 high strobes (din = 10 / 50) SHALL produce no drdy; high #64 after low #64 SHALL produce RSSI = 40 internally and still no drdy.
REQ-035 Steady state: alternating low = 10 and high = 50 for 64 + 128 high strobes -> first drdy, then dout = 40, with drdy 3 cycles after each high strobe.
REQ-036 Clamp: low = 50 and high = 10 with windows full -> sat pulse per high strobe and dout converging to 0.
REQ-037 Step: after the steady state of REQ-035, switch high to 114 -> dout rises monotonically and reaches 104 after 64 + 128 further high strobes.
REQ-038 Reset mid-stream: assert rst for 1 cycle between a high strobe and its drdy -> no drdy, and the REQ-034 fill behaviour repeats from scratch.
